// File: rtl/tsense_spi_scheduler_if.sv
// Purpose: pin/result bundle between the sensor scan controller and its environment.
// Latency: none, wires only.
// Backpressure: none; results are pulse-qualified (DATA_VALID, SCAN_DONE) and not stallable.
// Signals: EN, ONESHOT, THRESH and SIO flow into the scheduler. SCK, CS_N, TEMP_ALL,
//          DATA_VALID, DATA_IDX, ALARM, SCAN_DONE and BUSY flow out of it.
interface tsense_spi_scheduler_if #(
    parameter int NSENS = 4
);
    localparam int IW = $clog2(NSENS);

    logic                 EN;
    logic                 ONESHOT;
    logic [7:0]           THRESH;
    logic                 SIO;
    logic                 SCK;
    logic [NSENS-1:0]     CS_N;
    logic [8*NSENS-1:0]   TEMP_ALL;
    logic                 DATA_VALID;
    logic [IW-1:0]        DATA_IDX;
    logic [NSENS-1:0]     ALARM;
    logic                 SCAN_DONE;
    logic                 BUSY;

    // Scheduler side: drives the SPI pins and the result store.
    modport master (
        input  EN, ONESHOT, THRESH, SIO,
        output SCK, CS_N, TEMP_ALL, DATA_VALID, DATA_IDX, ALARM, SCAN_DONE, BUSY
    );

    // Environment side: sensors plus control/consumer logic.
    modport slave (
        output EN, ONESHOT, THRESH, SIO,
        input  SCK, CS_N, TEMP_ALL, DATA_VALID, DATA_IDX, ALARM, SCAN_DONE, BUSY
    );
endinterface

// File: rtl/tsense_spi_scheduler.sv
// Purpose: round-robin 8-bit SPI read of NSENS temperature sensors on a shared SCK/SIO bus.
// Latency: CS_N low 1 cycle after EN/ONESHOT; per-sensor period SETUP_CYC+16+1+GAP_CYC cycles.
// Backpressure: none; results are one-cycle DATA_VALID pulses into a register store.
// Ports: SYSCLK/RSTN plain clock and async active-low reset; everything else via bus
//        (master modport): EN/ONESHOT control, THRESH signed alarm level, SIO serial in,
//        SCK/CS_N to the sensors, TEMP_ALL/ALARM stores, DATA_VALID/DATA_IDX/SCAN_DONE/BUSY status.
module tsense_spi_scheduler #(
    parameter int NSENS     = 4,
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 8
) (
    input  logic                          SYSCLK,
    input  logic                          RSTN,
    tsense_spi_scheduler_if.master        bus
);
    localparam int IW   = $clog2(NSENS);
    localparam int CMAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           hc_q, hc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 oneshot_q, oneshot_d;
    logic [7:0]           shift_q, shift_d;
    logic                 sck_q, sck_d;
    logic [NSENS-1:0]     cs_n_q, cs_n_d;
    logic [8*NSENS-1:0]   temp_q, temp_d;
    logic [NSENS-1:0]     alarm_q, alarm_d;
    logic                 dv_q, dv_d;
    logic [IW-1:0]        didx_q, didx_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 last_idx;

    assign last_idx = (idx_q == IW'(NSENS - 1));

    // Next-state logic. Counters are reset on state entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hc_d      = hc_q;
        idx_d     = idx_q;
        oneshot_d = oneshot_q;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                if (bus.EN) begin
                    state_d   = S_SETUP;
                    oneshot_d = 1'b0;
                end else if (bus.ONESHOT) begin
                    state_d   = S_SETUP;
                    oneshot_d = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    hc_d    = 4'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (hc_q == 4'd15) begin
                    state_d = S_HOLD;
                end else begin
                    hc_d = hc_q + 4'd1;
                end
            end
            S_HOLD: begin
                state_d = S_GAP;
                cnt_d   = '0;
                hc_d    = 4'd0;
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    idx_d = last_idx ? '0 : idx_q + 1'b1;
                    if (oneshot_q && last_idx) begin
                        // End of a single scan; EN held high turns it into continuous mode.
                        oneshot_d = 1'b0;
                        state_d   = bus.EN ? S_SETUP : S_IDLE;
                    end else if (oneshot_q || bus.EN) begin
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin is a flop that
    // already shows the new state's value during the state's first cycle.
    always_comb begin
        sck_d   = 1'b0;
        cs_n_d  = '1;
        shift_d = shift_q;
        temp_d  = temp_q;
        alarm_d = alarm_q;
        dv_d    = 1'b0;
        didx_d  = didx_q;
        done_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);

        if (state_d == S_SETUP || state_d == S_SHIFT) begin
            cs_n_d[idx_d] = 1'b0;
        end

        // SIO is captured on the same edge that raises SCK (even half-bits).
        if (state_d == S_SHIFT && !hc_d[0]) begin
            sck_d   = 1'b1;
            shift_d = {shift_q[6:0], bus.SIO};
        end

        if (state_d == S_HOLD) begin
            temp_d[8*idx_q +: 8] = shift_q;
            alarm_d[idx_q]       = ($signed(shift_q) >= $signed(bus.THRESH));
            dv_d                 = 1'b1;
            didx_d               = idx_q;
            done_d               = last_idx;
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hc_q      <= 4'd0;
            idx_q     <= '0;
            oneshot_q <= 1'b0;
            shift_q   <= 8'h00;
            sck_q     <= 1'b0;
            cs_n_q    <= '1;
            temp_q    <= '0;
            alarm_q   <= '0;
            dv_q      <= 1'b0;
            didx_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hc_q      <= hc_d;
            idx_q     <= idx_d;
            oneshot_q <= oneshot_d;
            shift_q   <= shift_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            temp_q    <= temp_d;
            alarm_q   <= alarm_d;
            dv_q      <= dv_d;
            didx_q    <= didx_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.SCK        = sck_q;
    assign bus.CS_N       = cs_n_q;
    assign bus.TEMP_ALL   = temp_q;
    assign bus.ALARM      = alarm_q;
    assign bus.DATA_VALID = dv_q;
    assign bus.DATA_IDX   = didx_q;
    assign bus.SCAN_DONE  = done_q;
    assign bus.BUSY       = busy_q;
endmodule
